// File: rtl/viterbi_pkg.sv
// Shared encoder/decoder definitions: FSM states, configuration decode, lane sizes.
package viterbi_pkg;

  localparam int SOFT_LANE_W = 4;
  localparam int MAX_POLY    = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_TAIL = 2'd2
  } enc_state_t;

  // register_num code -> memory depth m (00->6 ... 11->3)
  function automatic logic [2:0] decode_m(input logic [1:0] code);
    return 3'd6 - {1'b0, code};
  endfunction

  // valid_polynomials code -> number of active outputs n
  function automatic logic [2:0] decode_n(input logic [2:0] code);
    case (code)
      3'b000:  return 3'd6;
      3'b001:  return 3'd5;
      3'b010:  return 3'd4;
      3'b011:  return 3'd3;
      default: return 3'd2;
    endcase
  endfunction

endpackage

// File: rtl/conv_enc_parity.sv
// One codeword bit: masked XOR of the tap vector against a generator polynomial.
module conv_enc_parity (
  input  logic [7:0] taps,
  input  logic [7:0] poly,
  input  logic [7:0] mask,
  output logic       parity
);

  assign parity = ^(taps & poly & mask);

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/n feed-forward convolutional encoder with antipodal soft output.
// Define CONV_ENC_TAIL_EN to enable zero-tail termination (TAIL state).
module conv_encoder
  import viterbi_pkg::*;
#(
  parameter int SOFT_MAG = 7
) (
  input  logic        clk_i,
  input  logic        rst_an_i,
  input  logic        rst_sync_i,
  input  logic        start_i,
  input  logic [1:0]  register_num_i,
  input  logic [2:0]  valid_polynomials_i,
  input  logic [7:0]  polynomial1_i,
  input  logic [7:0]  polynomial2_i,
  input  logic [7:0]  polynomial3_i,
  input  logic [7:0]  polynomial4_i,
  input  logic [7:0]  polynomial5_i,
  input  logic [7:0]  polynomial6_i,
  input  logic        data_i,
  input  logic        data_valid_i,
  input  logic        data_last_i,
  output logic        data_ready_o,
  output logic [5:0]  code_o,
  output logic [23:0] soft_o,
  output logic        code_valid_o,
  input  logic        code_ready_i,
  output logic        frame_done_o,
  output logic        busy_o
);

  localparam int SOFT_W = MAX_POLY * SOFT_LANE_W;

  enc_state_t state, state_nxt;

  logic [1:0]        reg_code;
  logic [2:0]        vp_code;
  logic [7:0]        poly_q  [MAX_POLY];
  logic [7:0]        poly_in [MAX_POLY];
  logic [5:0]        s_q;
  logic [2:0]        tail_cnt;
  logic [5:0]        code_q;
  logic [SOFT_W-1:0] soft_q;
  logic              code_vld;
  logic              last_q;

  logic [2:0]        m;
  logic [2:0]        n;
  logic [7:0]        mask;
  logic [7:0]        taps;
  logic [MAX_POLY-1:0] par;
  logic [5:0]        code_nxt;
  logic [SOFT_W-1:0] soft_nxt;
  logic              advance;
  logic              accept;
  logic              tail_step;
  logic              load;
  logic              word_last;
  logic              u;

  function automatic logic [SOFT_LANE_W-1:0] soft_lane(input logic c, input logic act);
    logic signed [SOFT_LANE_W-1:0] mag;
    mag = SOFT_LANE_W'(SOFT_MAG);
    if (!act) return '0;
    return c ? mag : -mag;
  endfunction

  assign poly_in = '{polynomial1_i, polynomial2_i, polynomial3_i,
                     polynomial4_i, polynomial5_i, polynomial6_i};

  assign m       = decode_m(reg_code);
  assign n       = decode_n(vp_code);
  assign mask    = (8'd2 << m) - 8'd1;
  assign advance = !code_vld || code_ready_i;
  assign load    = accept || tail_step;
  // Tail words are generated from a zero input to flush the shift state
  assign u       = (state == ST_TAIL) ? 1'b0 : data_i;
  assign taps    = {1'b0, s_q, u};

  for (genvar j = 0; j < MAX_POLY; j++) begin : g_par
    conv_enc_parity u_parity (
      .taps   (taps),
      .poly   (poly_q[j]),
      .mask   (mask),
      .parity (par[j])
    );
  end

  always_comb begin
    code_nxt = '0;
    soft_nxt = '0;
    for (int j = 0; j < MAX_POLY; j++) begin
      code_nxt[j] = par[j] && (3'(j) < n);
      soft_nxt[j*SOFT_LANE_W +: SOFT_LANE_W] = soft_lane(par[j], 3'(j) < n);
    end
  end

  always_comb begin
    state_nxt    = state;
    data_ready_o = 1'b0;
    accept       = 1'b0;
    tail_step    = 1'b0;
    word_last    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        data_ready_o = advance;
        accept       = data_valid_i && advance;
        if (accept && data_last_i) begin
`ifdef CONV_ENC_TAIL_EN
          state_nxt = ST_TAIL;
`else
          state_nxt = ST_IDLE;
          word_last = 1'b1;
`endif
        end
      end
      ST_TAIL: begin
        tail_step = advance;
        if (tail_step && (tail_cnt == m - 3'd1)) begin
          state_nxt = ST_IDLE;
          word_last = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i)       state <= ST_IDLE;
    else if (rst_sync_i) state <= ST_IDLE;
    else                 state <= state_nxt;
  end

  // Configuration latch, shift state and the single output register stage
  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      reg_code <= '0;
      vp_code  <= '0;
      for (int j = 0; j < MAX_POLY; j++) poly_q[j] <= '0;
      s_q      <= '0;
      tail_cnt <= '0;
      code_q   <= '0;
      soft_q   <= '0;
      code_vld <= 1'b0;
      last_q   <= 1'b0;
    end else if (rst_sync_i) begin
      reg_code <= '0;
      vp_code  <= '0;
      for (int j = 0; j < MAX_POLY; j++) poly_q[j] <= '0;
      s_q      <= '0;
      tail_cnt <= '0;
      code_q   <= '0;
      soft_q   <= '0;
      code_vld <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && start_i) begin
        reg_code <= register_num_i;
        vp_code  <= valid_polynomials_i;
        for (int j = 0; j < MAX_POLY; j++) poly_q[j] <= poly_in[j];
        s_q      <= '0;
        tail_cnt <= '0;
      end else if (load) begin
        s_q <= {s_q[4:0], u};
        if (tail_step) tail_cnt <= tail_cnt + 3'd1;
      end

      if (load) begin
        code_q   <= code_nxt;
        soft_q   <= soft_nxt;
        code_vld <= 1'b1;
        last_q   <= word_last;
      end else if (code_ready_i) begin
        code_vld <= 1'b0;
        last_q   <= 1'b0;
      end
    end
  end

  assign code_o       = code_q;
  assign soft_o       = soft_q;
  assign code_valid_o = code_vld;
  assign frame_done_o = code_vld && code_ready_i && last_q;
  assign busy_o       = (state != ST_IDLE);

endmodule
